// File: rtl/reset_request_generator_pkg.sv
// Shared definitions for the reset request generator.
//   Cause bit indices into reset_cause, FSM state encodings, and a saturating
//   increment used by the request counter.
package reset_request_generator_pkg;

  localparam int unsigned CAUSE_BUTTON   = 0;
  localparam int unsigned CAUSE_SOFTWARE = 1;
  localparam int unsigned CAUSE_WATCHDOG = 2;
  localparam int unsigned CAUSE_PLL      = 3;
  localparam int unsigned CAUSE_W        = 4;

  localparam int unsigned COUNT_W = 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ASSERT  = 2'd1;
  localparam logic [1:0] HOLDOFF = 2'd2;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (&value) ? value : value + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/reset_request_generator_if.sv
// Request/status bundle of the reset request generator.
//   master: request sources and status reader (drives requests, reads status)
//   slave : the generator (reads requests, drives reset_request and status)
interface reset_request_generator_if;
  import reset_request_generator_pkg::*;

  logic                 button_input;
  logic                 software_request;
  logic                 watchdog_enable;
  logic                 watchdog_kick;
  logic                 pll_locked_input;
  logic                 reset_cause_clear;
  logic                 reset_request;
  logic                 busy;
  logic [CAUSE_W-1:0]   reset_cause;
  logic [COUNT_W-1:0]   reset_count;

  modport master (
    output button_input, software_request, watchdog_enable, watchdog_kick,
           pll_locked_input, reset_cause_clear,
    input  reset_request, busy, reset_cause, reset_count
  );

  modport slave (
    input  button_input, software_request, watchdog_enable, watchdog_kick,
           pll_locked_input, reset_cause_clear,
    output reset_request, busy, reset_cause, reset_count
  );

endinterface

// File: rtl/reset_request_debounce.sv
// Pushbutton debouncer with built-in resynchronizer.
//   clock, reset : system clock, async active-high reset
//   in           : raw asynchronous button level
//   stable       : debounced level; follows in after 2**BIT_PICKOFF steady clocks
//   rise         : one-clock pulse on a 0->1 change of stable
module reset_request_debounce #(
  parameter int unsigned BIT_PICKOFF = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic stable,
  output logic rise
);

  logic                 sync;
  logic [BIT_PICKOFF:0] count_q, count_next;
  logic                 stable_q, rise_q;

  reset_request_resync u_resync (
    .clock    (clock),
    .reset    (reset),
    .async_in (in),
    .sync_out (sync)
  );

  assign count_next = count_q + (BIT_PICKOFF + 1)'(1);

  // Count only while the synced level disagrees with the accepted level; any
  // bounce back to the accepted level restarts the interval.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      if (sync == stable_q) begin
        count_q <= '0;
      end else if (count_next[BIT_PICKOFF]) begin
        count_q  <= '0;
        stable_q <= sync;
        rise_q   <= sync;
      end else begin
        count_q <= count_next;
      end
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/reset_request_resync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
//   clock, reset : system clock, async active-high reset (output clears to 0)
//   async_in     : asynchronous input
//   sync_out     : input resynchronized to clock, two cycles of latency
module reset_request_resync (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/reset_request_generator.sv
// Reset request generator: merges button, software, watchdog and PLL-loss
// requests into one stretched, rate-limited reset_request pulse.
//   clock : free-running system clock
//   reset : async active-high, clears all state
//   bus   : requests in (button, software, watchdog enable/kick, pll lock,
//           cause clear); reset_request, busy, sticky reset_cause and
//           saturating reset_count out
module reset_request_generator
  import reset_request_generator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_BIT_PICKOFF = 16,
  parameter int unsigned PULSE_BIT_PICKOFF    = 8,
  parameter int unsigned HOLDOFF_BIT_PICKOFF  = 10,
  parameter int unsigned WATCHDOG_BIT_PICKOFF = 24
) (
  input  logic                       clock,
  input  logic                       reset,
  reset_request_generator_if.slave   bus
);

  localparam int unsigned CntW = (PULSE_BIT_PICKOFF > HOLDOFF_BIT_PICKOFF) ?
                                 PULSE_BIT_PICKOFF : HOLDOFF_BIT_PICKOFF;
  localparam logic [CntW-1:0] PulseLast = CntW'((32'd1 << PULSE_BIT_PICKOFF) - 32'd1);
  localparam logic [CntW-1:0] HoldLast  = CntW'((32'd1 << HOLDOFF_BIT_PICKOFF) - 32'd1);

  // Button
  logic button_stable, button_rise;

  reset_request_debounce #(
    .BIT_PICKOFF (DEBOUNCE_BIT_PICKOFF)
  ) u_debounce (
    .clock  (clock),
    .reset  (reset),
    .in     (bus.button_input),
    .stable (button_stable),
    .rise   (button_rise)
  );

  // PLL loss: only a lock that was once seen can be lost.
  logic pll_sync, pll_armed_q, pll_prev_q, pll_loss;

  reset_request_resync u_pll_resync (
    .clock    (clock),
    .reset    (reset),
    .async_in (bus.pll_locked_input),
    .sync_out (pll_sync)
  );

  assign pll_loss = pll_armed_q & pll_prev_q & ~pll_sync;

  // State
  logic [1:0]                  state_q, state_d;
  logic [CntW-1:0]             phase_q, phase_d;
  logic                        req_q, req_d;
  logic                        busy_q, busy_d;
  logic [CAUSE_W-1:0]          cause_q, cause_d;
  logic [COUNT_W-1:0]          count_q, count_d;
  logic [WATCHDOG_BIT_PICKOFF:0] wd_q, wd_d, wd_next;
  logic                        wd_fire_q, wd_fire_d;
  logic [CAUSE_W-1:0]          events;

  always_comb begin
    events                 = '0;
    events[CAUSE_BUTTON]   = button_rise;
    events[CAUSE_SOFTWARE] = bus.software_request;
    events[CAUSE_WATCHDOG] = wd_fire_q;
    events[CAUSE_PLL]      = pll_loss;
  end

  // Watchdog runs only while idle; firing clears the counter on the same edge.
  always_comb begin
    wd_next   = wd_q + (WATCHDOG_BIT_PICKOFF + 1)'(1);
    wd_d      = wd_next;
    wd_fire_d = 1'b0;
    if (!bus.watchdog_enable || bus.watchdog_kick || (state_q != IDLE)) begin
      wd_d = '0;
    end else if (wd_next[WATCHDOG_BIT_PICKOFF]) begin
      wd_d      = '0;
      wd_fire_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + CntW'(1);
    req_d   = req_q;
    busy_d  = busy_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        req_d   = 1'b0;
        busy_d  = 1'b0;
        if (|events) begin
          state_d = ASSERT;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          count_d = sat_inc(count_q);
        end
      end
      ASSERT: begin
        if (phase_q == PulseLast) begin
          state_d = HOLDOFF;
          req_d   = 1'b0;
          phase_d = '0;
        end
      end
      HOLDOFF: begin
        if (phase_q == HoldLast) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          phase_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
        phase_d = '0;
      end
    endcase
    // Events in any state are recorded; a coincident clear loses only older bits.
    cause_d = (bus.reset_cause_clear ? '0 : cause_q) | events;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      cause_q     <= '0;
      count_q     <= '0;
      wd_q        <= '0;
      wd_fire_q   <= 1'b0;
      pll_armed_q <= 1'b0;
      pll_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
      wd_q        <= wd_d;
      wd_fire_q   <= wd_fire_d;
      pll_armed_q <= pll_armed_q | pll_sync;
      pll_prev_q  <= pll_sync;
    end
  end

  assign bus.reset_request = req_q;
  assign bus.busy          = busy_q;
  assign bus.reset_cause   = cause_q;
  assign bus.reset_count   = count_q;

endmodule

// File: tb/tb_reset_request_generator.sv
// Self-checking bench for reset_request_generator (DEBOUNCE=2, PULSE=3,
// HOLDOFF=4, WATCHDOG=6): a run-length vector table for the software-request
// path, then directed sequences for button, PLL, watchdog, saturation, reset.
module tb_reset_request_generator;

  logic clock = 1'b0;
  logic reset = 1'b1;

  reset_request_generator_if bus ();

  reset_request_generator #(
    .DEBOUNCE_BIT_PICKOFF (2),
    .PULSE_BIT_PICKOFF    (3),
    .HOLDOFF_BIT_PICKOFF  (4),
    .WATCHDOG_BIT_PICKOFF (6)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses = 0;
  logic req_prev = 1'b0;

  // Rising edges of reset_request seen on the clock.
  always @(posedge clock) begin
    req_prev <= bus.reset_request;
    if (bus.reset_request && !req_prev) pulses <= pulses + 1;
  end

  typedef struct {
    logic        sw;
    logic        clr;
    int unsigned n;
    logic        req;
    logic        busy;
    logic [3:0]  cause;
    logic [7:0]  count;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic sw, input logic clr, input int unsigned n,
                              input logic req, input logic busy, input logic [3:0] cause,
                              input logic [7:0] count);
    vec_t v;
    v.sw = sw; v.clr = clr; v.n = n; v.req = req; v.busy = busy;
    v.cause = cause; v.count = count;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    logic [7:0] exp_count;
    logic [13:0] got, want;

    bus.button_input      = 1'b0;
    bus.software_request  = 1'b0;
    bus.watchdog_enable   = 1'b0;
    bus.watchdog_kick     = 1'b0;
    bus.pll_locked_input  = 1'b0;
    bus.reset_cause_clear = 1'b0;

    steps(2);
    check("reset_state", 32'({bus.reset_request, bus.busy, bus.reset_cause, bus.reset_count}),
          32'd0);
    reset = 1'b0;

    // Software path; PLL lock held 0 since reset throughout.
    add(0, 0,  3, 0, 0, 4'h0, 8'd0);
    add(1, 0,  1, 1, 1, 4'h2, 8'd1);
    add(0, 0,  7, 1, 1, 4'h2, 8'd1);
    add(0, 0, 16, 0, 1, 4'h2, 8'd1);
    add(0, 0,  2, 0, 0, 4'h2, 8'd1);
    add(0, 1,  1, 0, 0, 4'h0, 8'd1);
    add(1, 1,  1, 1, 1, 4'h2, 8'd2);
    add(0, 0,  7, 1, 1, 4'h2, 8'd2);
    add(0, 0, 16, 0, 1, 4'h2, 8'd2);
    add(0, 0,  1, 0, 0, 4'h2, 8'd2);
    // Held request: one pulse, retriggers only once back in IDLE.
    add(1, 0,  1, 1, 1, 4'h2, 8'd3);
    add(1, 0,  7, 1, 1, 4'h2, 8'd3);
    add(1, 0, 16, 0, 1, 4'h2, 8'd3);
    add(1, 0,  1, 0, 0, 4'h2, 8'd3);
    add(1, 0,  1, 1, 1, 4'h2, 8'd4);
    add(0, 0,  7, 1, 1, 4'h2, 8'd4);
    add(0, 0, 16, 0, 1, 4'h2, 8'd4);
    add(0, 0,  2, 0, 0, 4'h2, 8'd4);

    foreach (vecs[i]) begin
      for (int c = 0; c < int'(vecs[i].n); c++) begin
        bus.software_request  = vecs[i].sw;
        bus.reset_cause_clear = vecs[i].clr;
        step();
        got  = {bus.reset_request, bus.busy, bus.reset_cause, bus.reset_count};
        want = {vecs[i].req, vecs[i].busy, vecs[i].cause, vecs[i].count};
        check($sformatf("vec%0d_cyc%0d", i, c), 32'(got), 32'(want));
      end
    end
    bus.software_request  = 1'b0;
    bus.reset_cause_clear = 1'b0;
    exp_count = 8'd4;

    // PLL loss in IDLE: 3-clock latency.
    bus.reset_cause_clear = 1'b1; step(); bus.reset_cause_clear = 1'b0;
    bus.pll_locked_input = 1'b1; steps(5);
    bus.pll_locked_input = 1'b0;
    step(); check("pll_lat1", 32'(bus.reset_request), 32'd0);
    step(); check("pll_lat2", 32'(bus.reset_request), 32'd0);
    step(); check("pll_lat3", 32'(bus.reset_request), 32'd1);
    exp_count++;
    check("pll_cause", 32'(bus.reset_cause), 32'h8);
    check("pll_count", 32'(bus.reset_count), 32'(exp_count));
    steps(24);
    check("pll_busy_done", 32'(bus.busy), 32'd0);

    // PLL loss during HOLDOFF: cause only.
    bus.reset_cause_clear = 1'b1; step(); bus.reset_cause_clear = 1'b0;
    bus.pll_locked_input = 1'b1; steps(5);
    p0 = pulses;
    bus.software_request = 1'b1; step(); bus.software_request = 1'b0;
    exp_count++;
    steps(9);
    check("holdoff_req", 32'(bus.reset_request), 32'd0);
    bus.pll_locked_input = 1'b0;
    steps(30);
    check("holdoff_pulses", 32'(pulses - p0), 32'd1);
    check("holdoff_cause", 32'(bus.reset_cause), 32'ha);
    check("holdoff_count", 32'(bus.reset_count), 32'(exp_count));

    // Clear coinciding with a software event keeps only the software bit.
    bus.reset_cause_clear = 1'b1; bus.software_request = 1'b1; step();
    bus.reset_cause_clear = 1'b0; bus.software_request = 1'b0;
    exp_count++;
    check("clr_evt_cause", 32'(bus.reset_cause), 32'h2);
    check("clr_evt_count", 32'(bus.reset_count), 32'(exp_count));
    steps(24);

    // Bouncy button then held: one pulse 3+4 clocks after the final rise.
    bus.reset_cause_clear = 1'b1; step(); bus.reset_cause_clear = 1'b0;
    p0 = pulses;
    bus.button_input = 1'b1; steps(2);
    bus.button_input = 1'b0; steps(2);
    bus.button_input = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 6) check("btn_lat_pre", 32'(bus.reset_request), 32'd0);
      if (k == 7) check("btn_lat", 32'(bus.reset_request), 32'd1);
    end
    bus.button_input = 1'b0;
    steps(40);
    exp_count++;
    check("btn_pulses", 32'(pulses - p0), 32'd1);
    check("btn_cause", 32'(bus.reset_cause), 32'h1);
    check("btn_count", 32'(bus.reset_count), 32'(exp_count));

    // Watchdog without kicks fires on clock 65.
    bus.reset_cause_clear = 1'b1; step(); bus.reset_cause_clear = 1'b0;
    bus.watchdog_enable = 1'b1;
    for (int k = 1; k <= 65; k++) begin
      step();
      if (k == 64) check("wd_pre", 32'(bus.reset_request), 32'd0);
    end
    exp_count++;
    check("wd_fire", 32'(bus.reset_request), 32'd1);
    check("wd_cause", 32'(bus.reset_cause), 32'h4);
    check("wd_count", 32'(bus.reset_count), 32'(exp_count));
    steps(24);
    check("wd_busy_done", 32'(bus.busy), 32'd0);
    p0 = pulses;
    for (int i = 0; i < 1000; i++) begin
      bus.watchdog_kick = (i % 50 == 0);
      step();
    end
    bus.watchdog_kick = 1'b0;
    check("wd_kicked_pulses", 32'(pulses - p0), 32'd0);
    check("wd_kicked_count", 32'(bus.reset_count), 32'(exp_count));

    // Software and watchdog on the same edge.
    bus.watchdog_enable = 1'b0; bus.reset_cause_clear = 1'b1; step();
    bus.reset_cause_clear = 1'b0;
    bus.watchdog_enable = 1'b1;
    p0 = pulses;
    for (int k = 1; k <= 65; k++) begin
      if (k == 65) bus.software_request = 1'b1;
      step();
      if (k == 64) check("both_pre", 32'(bus.reset_request), 32'd0);
    end
    bus.software_request = 1'b0;
    bus.watchdog_enable  = 1'b0;
    exp_count++;
    check("both_req", 32'(bus.reset_request), 32'd1);
    check("both_cause", 32'(bus.reset_cause), 32'h6);
    check("both_count", 32'(bus.reset_count), 32'(exp_count));
    steps(30);
    check("both_pulses", 32'(pulses - p0), 32'd1);

    // Saturation after 300 requests.
    for (int i = 0; i < 300; i++) begin
      bus.software_request = 1'b1; step();
      bus.software_request = 1'b0; steps(24);
    end
    check("sat_count", 32'(bus.reset_count), 32'd255);

    // Async reset in the middle of ASSERT.
    bus.software_request = 1'b1; step();
    bus.software_request = 1'b0; steps(3);
    check("mid_assert_req", 32'(bus.reset_request), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset", 32'({bus.reset_request, bus.busy, bus.reset_cause, bus.reset_count}),
          32'd0);
    step();
    reset = 1'b0;
    p0 = pulses;
    steps(40);
    check("post_reset_pulses", 32'(pulses - p0), 32'd0);
    check("post_reset_state", 32'({bus.reset_request, bus.busy, bus.reset_cause,
                                   bus.reset_count}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
